// File: rtl/add_arb_pkg.sv
// Shared definitions for the add_arb round-robin adder arbiter:
// size limits, FSM state type and the rotating-priority grant function.
package add_arb_pkg;

    localparam int NREQ_MAX  = 8;
    localparam int IDX_MAX_W = $clog2(NREQ_MAX);

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

    // Search starts just after the last winner and wraps round to it, so the
    // winner of the previous grant has the lowest priority this time.
    function automatic logic [NREQ_MAX-1:0] arb_pick(
        input logic [NREQ_MAX-1:0]  valid,
        input logic [IDX_MAX_W-1:0] last,
        input int                   nreq
    );
        logic [NREQ_MAX-1:0] grant;
        logic                found;
        int                  idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            if (k <= nreq && !found) begin
                idx = (int'(last) + k) % nreq;
                if (valid[idx[IDX_MAX_W-1:0]]) begin
                    grant[idx[IDX_MAX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/add_arb_adder8.sv
// adder8: plain 8-bit ripple-carry adder shared by all add_arb requesters.
module adder8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar g = 0; g < 8; g++) begin : gen_fa
        assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_carry[8];

endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin arbiter feeding one shared adder8 into a single response register.
// Define ADD_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module add_arb
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id
`ifdef ADD_ARB_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    arb_state_t          r_state;
    logic [IDW-1:0]      r_last;
    logic [7:0]          r_sum;
    logic                r_cout;
    logic [IDW-1:0]      r_id;
`ifdef ADD_ARB_OVF_EN
    logic                r_ovf;
`endif

    logic [NREQ_MAX-1:0]  w_validExt;
    logic [IDX_MAX_W-1:0] w_lastExt;
    logic [NREQ_MAX-1:0]  w_pick;
    logic [NREQ-1:0]      w_grant;
    logic                 w_anyGrant;
    logic                 w_accept;
    logic                 w_fire;
    logic [IDW-1:0]       w_grantIdx;
    logic [7:0]           w_a;
    logic [7:0]           w_b;
    logic [7:0]           w_sum;
    logic                 w_cout;

    always_comb begin
        w_validExt             = '0;
        w_validExt[NREQ-1:0]   = req_valid;
        w_lastExt              = '0;
        w_lastExt[IDW-1:0]     = r_last;
    end

    assign w_pick     = arb_pick(w_validExt, w_lastExt, NREQ);
    assign w_grant    = w_pick[NREQ-1:0];
    assign w_anyGrant = |w_pick;

    // The register can take a new result when empty or when its current one leaves this cycle.
    assign w_accept   = reset_n && ((r_state == ARB_EMPTY) || rsp_ready);
    assign w_fire     = w_accept && w_anyGrant;
    assign req_ready  = w_accept ? w_grant : '0;

    always_comb begin
        w_grantIdx = '0;
        w_a        = '0;
        w_b        = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grantIdx = IDW'(i);
                w_a        = req_a[8*i +: 8];
                w_b        = req_b[8*i +: 8];
            end
        end
    end

    adder8 u_adder8 (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_EMPTY;
            r_last  <= IDW'(NREQ - 1);
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
`ifdef ADD_ARB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_fire) begin
            r_state <= ARB_FULL;
            r_last  <= w_grantIdx;
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_id    <= w_grantIdx;
`ifdef ADD_ARB_OVF_EN
            r_ovf   <= (w_a[7] == w_b[7]) && (w_sum[7] != w_a[7]);
`endif
        end else if (r_state == ARB_FULL && rsp_ready) begin
            r_state <= ARB_EMPTY;
        end
    end

    assign rsp_valid = (r_state == ARB_FULL);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;
`ifdef ADD_ARB_OVF_EN
    assign rsp_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_add_arb.sv
// Testbench for add_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_add_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [7:0]        rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
`ifdef ADD_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;

    bit         mFull;
    logic [7:0] mSum;
    bit         mCout;
    int         mId;
    int         mLast;
    bit         mOvf;
    logic [NREQ-1:0] lastReady;

    always #5 clk = ~clk;

    add_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
`ifdef ADD_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic checkLit(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mFull = 1'b0;
        mSum  = 8'h00;
        mCout = 1'b0;
        mId   = 0;
        mOvf  = 1'b0;
        mLast = NREQ - 1;
    endtask

    function automatic int modelPick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic checkOutput();
        int pick;
        bit acc;
        logic [NREQ-1:0] expReady;
        if (!reset_n) modelReset();
        acc  = reset_n && (!mFull || rsp_ready);
        pick = modelPick(req_valid, mLast);
        expReady = '0;
        if (acc && pick >= 0) expReady[pick] = 1'b1;
        checkLit("req_ready", int'(req_ready), int'(expReady));
        checkLit("rsp_valid", int'(rsp_valid), int'(mFull));
        if (mFull) begin
            checkLit("rsp_sum",  int'(rsp_sum),  int'(mSum));
            checkLit("rsp_cout", int'(rsp_cout), int'(mCout));
            checkLit("rsp_id",   int'(rsp_id),   mId);
`ifdef ADD_ARB_OVF_EN
            checkLit("rsp_ovf",  int'(rsp_ovf),  int'(mOvf));
`endif
        end
        lastReady = req_ready;
    endtask

    // One cycle: drive after the falling edge, check before the rising edge, then advance the model.
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] a,
                                 input logic [8*NREQ-1:0] b, input logic rr);
        int pick;
        bit acc;
        int s;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        checkOutput();
        acc  = reset_n && (!mFull || rr);
        pick = modelPick(v, mLast);
        @(posedge clk);
        if (!reset_n) begin
            modelReset();
        end else if (acc && pick >= 0) begin
            s     = int'(a[8*pick +: 8]) + int'(b[8*pick +: 8]);
            mSum  = s[7:0];
            mCout = s[8];
            mId   = pick;
            mLast = pick;
            mOvf  = (a[8*pick+7] == b[8*pick+7]) && (s[7] != a[8*pick+7]);
            mFull = 1'b1;
        end else if (mFull && rr) begin
            mFull = 1'b0;
        end
        #1;
    endtask

    logic [NREQ-1:0] curValid;
    logic [7:0]      curA [NREQ];
    logic [7:0]      curB [NREQ];

    function automatic logic [7:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [8*NREQ-1:0] ra;
        logic [8*NREQ-1:0] rb;
        modelReset();

        applyStimulus(4'b1111, 32'h01020304, 32'h05060708, 1'b1);
        checkLit("reset_rsp_valid", int'(rsp_valid), 0);
        checkLit("reset_rsp_sum",   int'(rsp_sum),   0);
        checkLit("reset_rsp_id",    int'(rsp_id),    0);
        checkLit("reset_req_ready", int'(lastReady), 0);
        reset_n = 1'b1;

        applyStimulus(4'b0001, 32'h00000012, 32'h00000034, 1'b1);
        checkLit("first_ready", int'(lastReady), 1);
        checkLit("first_valid", int'(rsp_valid), 1);
        checkLit("first_sum",   int'(rsp_sum),   'h46);
        checkLit("first_cout",  int'(rsp_cout),  0);
        checkLit("first_id",    int'(rsp_id),    0);

        applyStimulus(4'b0100, 32'h00FF0000, 32'h00010000, 1'b1);
        checkLit("carry_sum",  int'(rsp_sum),  0);
        checkLit("carry_cout", int'(rsp_cout), 1);
        checkLit("carry_id",   int'(rsp_id),   2);

`ifdef ADD_ARB_OVF_EN
        applyStimulus(4'b0100, 32'h007F0000, 32'h00010000, 1'b1);
        checkLit("ovf_sum", int'(rsp_sum), 'h80);
        checkLit("ovf_bit", int'(rsp_ovf), 1);
`endif

        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1);
        checkLit("drain_valid", int'(rsp_valid), 0);
        applyStimulus(4'b0010, 32'h00000500, 32'h00000600, 1'b0);
        checkLit("drain_regrant", int'(lastReady), 'b0010);
        checkLit("drain_sum",     int'(rsp_sum),   'h0B);
        checkLit("drain_id",      int'(rsp_id),    1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1010, 32'h01000200, 32'h03000400, 1'b0);
            checkLit("bp_ready", int'(lastReady), 0);
            checkLit("bp_id",    int'(rsp_id),    1);
            checkLit("bp_sum",   int'(rsp_sum),   'h0B);
        end
        applyStimulus(4'b1010, 32'h01000200, 32'h03000400, 1'b1);
        checkLit("bp_release_ready", int'(lastReady), 'b1000);
        checkLit("bp_release_id",    int'(rsp_id),    3);
        checkLit("bp_release_sum",   int'(rsp_sum),   'h04);

        @(negedge clk);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkLit("async_reset_valid", int'(rsp_valid), 0);
        checkLit("async_reset_ready", int'(req_ready), 0);
        applyStimulus(4'b1001, 32'h05000007, 32'h06000008, 1'b1);
        reset_n = 1'b1;
        applyStimulus(4'b1001, 32'h05000007, 32'h06000008, 1'b1);
        checkLit("tie_ready", int'(lastReady), 'b0001);
        checkLit("tie_id",    int'(rsp_id),    0);
        checkLit("tie_sum",   int'(rsp_sum),   'h0F);

        reset_n = 1'b0;
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 32'($urandom), 32'($urandom), 1'b1);
            checkLit("fair_id",    int'(rsp_id),    i % NREQ);
            checkLit("fair_valid", int'(rsp_valid), 1);
        end

        curValid  = '0;
        lastReady = '0;
        for (int i = 0; i < NREQ; i++) begin
            curA[i] = 8'h00;
            curB[i] = 8'h00;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (curValid[i] && !lastReady[i]) begin
                    if ($urandom_range(0, 7) == 0) curValid[i] = 1'b0;
                end else begin
                    curValid[i] = 1'($urandom_range(0, 1));
                    curA[i]     = pickOperand();
                    curB[i]     = pickOperand();
                end
                ra[8*i +: 8] = curA[i];
                rb[8*i +: 8] = curB[i];
            end
            applyStimulus(curValid, ra, rb, 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
